// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl: whack-a-mole round sequencer with timer, LFSR mole spawning and saturating score.
module whack_game_ctrl #(
    parameter int         N_HOLES     = 4,
    parameter int         GAME_SECS   = 60,
    parameter int         MOLE_CYCLES = 50_000_000,
    parameter int         GAP_CYCLES  = 25_000_000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sec_tick,
    input  logic [N_HOLES-1:0] hit,
    output logic [N_HOLES-1:0] mole,
    output logic [6:0]         time_left,
    output logic [7:0]         score,
    output logic               playing,
    output logic               game_over
);
    localparam int LW   = $clog2(N_HOLES);
    localparam int CMAX = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, OVER} state_t;

    state_t             state_q;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [LW-1:0]      last_q, idx_raw, idx_d;
    logic [CW-1:0]      cnt_q;
    logic [N_HOLES-1:0] mole_q;
    logic [6:0]         time_q;
    logic [7:0]         score_q, score_inc, score_dec;
    logic               playing_q, over_q, hit_ok, in_round;

    assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign idx_raw   = lfsr_q[LW-1:0];
    // never light the same hole twice in a row
    assign idx_d     = (idx_raw == last_q) ? idx_raw + 1'b1 : idx_raw;
    assign score_inc = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    assign score_dec = (score_q == 8'h00) ? score_q : score_q - 8'd1;
    assign hit_ok    = |(hit & mole_q);
    assign in_round  = (state_q == SPAWN) || (state_q == UP) || (state_q == GAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            last_q    <= '0;
            cnt_q     <= '0;
            mole_q    <= '0;
            time_q    <= 7'(GAME_SECS);
            score_q   <= '0;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                IDLE, OVER: begin
                    if (start) begin
                        state_q   <= SPAWN;
                        time_q    <= 7'(GAME_SECS);
                        score_q   <= '0;
                        playing_q <= 1'b1;
                        over_q    <= 1'b0;
                        mole_q    <= '0;
                        cnt_q     <= '0;
                    end
                end
                SPAWN: begin
                    mole_q  <= N_HOLES'(1) << idx_d;
                    last_q  <= idx_d;
                    cnt_q   <= '0;
                    state_q <= UP;
                end
                UP: begin
                    if (hit_ok) begin
                        score_q <= score_inc;
                        mole_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        if (|hit) score_q <= score_dec;
                        if (cnt_q == CW'(MOLE_CYCLES - 1)) begin
                            mole_q  <= '0;
                            cnt_q   <= '0;
                            state_q <= GAP;
                        end else cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (|hit) score_q <= score_dec;
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= SPAWN;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            // the final tick overrides whatever the round logic chose, except the score
            if (in_round && sec_tick && time_q != 7'd0) begin
                time_q <= time_q - 7'd1;
                if (time_q == 7'd1) begin
                    state_q   <= OVER;
                    mole_q    <= '0;
                    playing_q <= 1'b0;
                    over_q    <= 1'b1;
                end
            end
        end
    end

    assign mole      = mole_q;
    assign time_left = time_q;
    assign score     = score_q;
    assign playing   = playing_q;
    assign game_over = over_q;
endmodule

// File: tb/tb_whack_game_ctrl.sv
// tb_whack_game_ctrl: table-driven round checks plus spawn-order, saturation and async-reset sequences.
module tb_whack_game_ctrl;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, sec_tick = 1'b0;
    logic [3:0] hit = '0, mole;
    logic [6:0] time_left;
    logic [7:0] score;
    logic       playing, game_over;
    logic       rst2 = 1'b0, start2 = 1'b0, tick2 = 1'b0;
    logic [3:0] hit2 = '0, mole2;
    logic [6:0] time2;
    logic [7:0] score2;
    logic       play2, over2;

    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    whack_game_ctrl #(.N_HOLES(4), .GAME_SECS(5), .MOLE_CYCLES(4), .GAP_CYCLES(2), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .sec_tick(sec_tick), .hit(hit), .mole(mole),
        .time_left(time_left), .score(score), .playing(playing), .game_over(game_over));

    whack_game_ctrl #(.N_HOLES(4), .GAME_SECS(127), .MOLE_CYCLES(4), .GAP_CYCLES(2), .LFSR_SEED(8'hA5)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .sec_tick(tick2), .hit(hit2), .mole(mole2),
        .time_left(time2), .score(score2), .playing(play2), .game_over(over2));

    // reference spawn LFSR for dut2; ml_prev is the value seen during the previous cycle
    logic [7:0] ml, ml_prev;
    always @(posedge clk or posedge rst2) begin
        if (rst2) begin
            ml      <= 8'hA5;
            ml_prev <= 8'hA5;
        end else begin
            ml_prev <= ml;
            ml      <= {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
        end
    end

    typedef struct {
        logic       st;
        logic       tk;
        logic [1:0] hk;
        logic [6:0] t;
        logic [7:0] s;
        logic       p;
        logic       g;
        logic [1:0] mk;
    } vec_t;

    vec_t sbq[$];

    function automatic vec_t mkv(int st, int tk, int hk, int t, int s, int p, int g, int mk);
        vec_t v;
        v.st = st[0];
        v.tk = tk[0];
        v.hk = hk[1:0];
        v.t  = t[6:0];
        v.s  = s[7:0];
        v.p  = p[0];
        v.g  = g[0];
        v.mk = mk[1:0];
        return v;
    endfunction

    function automatic logic [3:0] wrong(logic [3:0] m);
        return (m == 4'b0000) ? 4'b1111 : {m[2:0], m[3]};
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic check_vec(int i, vec_t e);
        logic mole_ok;
        mole_ok = (e.mk == 2'd0) ? (mole === 4'b0000) : ($onehot(mole) === 1'b1);
        n_vec++;
        if (time_left !== e.t || score !== e.s || playing !== e.p || game_over !== e.g || !mole_ok) begin
            n_bad++;
            $display("FAIL vec %0d: got t=%0d s=%0d p=%b g=%b mole=%b, want t=%0d s=%0d p=%b g=%b mole_lit=%0d",
                     i, time_left, score, playing, game_over, mole, e.t, e.s, e.p, e.g, e.mk);
        end
    endtask

    task automatic apply(int i, vec_t v);
        start    = v.st;
        sec_tick = v.tk;
        hit      = (v.hk == 2'd1) ? mole : (v.hk == 2'd2) ? wrong(mole) : (v.hk == 2'd3) ? (mole | wrong(mole)) : 4'b0000;
        sbq.push_back(v);
        @(negedge clk);
        start    = 1'b0;
        sec_tick = 1'b0;
        hit      = '0;
        check_vec(i, sbq.pop_front());
    endtask

    task automatic wait_mole2(logic lit, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if ((mole2 != 4'b0000) == lit) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("mole2 wait timeout", 32'(mole2), 32'(lit));
    endtask

    localparam int NR = 35;
    int rows [NR][8] = '{
        '{1,1,0,5,0,1,0,0}, '{0,0,0,5,0,1,0,1}, '{0,0,1,5,1,1,0,0}, '{0,0,0,5,1,1,0,0},
        '{0,0,0,5,1,1,0,0}, '{0,0,0,5,1,1,0,1}, '{0,0,2,5,0,1,0,1}, '{0,0,2,5,0,1,0,1},
        '{0,0,3,5,1,1,0,0}, '{0,0,2,5,0,1,0,0}, '{1,0,0,5,0,1,0,0}, '{0,0,0,5,0,1,0,1},
        '{1,0,0,5,0,1,0,1}, '{0,0,0,5,0,1,0,1}, '{0,0,0,5,0,1,0,1}, '{0,0,0,5,0,1,0,0},
        '{0,0,0,5,0,1,0,0}, '{0,0,0,5,0,1,0,0}, '{0,0,0,5,0,1,0,1}, '{0,0,1,5,1,1,0,0},
        '{0,0,0,5,1,1,0,0}, '{0,0,0,5,1,1,0,0}, '{0,0,0,5,1,1,0,1}, '{0,1,0,4,1,1,0,1},
        '{0,1,0,3,1,1,0,1}, '{0,1,0,2,1,1,0,1}, '{0,0,0,2,1,1,0,0}, '{0,0,0,2,1,1,0,0},
        '{0,1,0,1,1,1,0,0}, '{0,0,0,1,1,1,0,1}, '{0,1,1,0,2,0,1,0}, '{0,1,1,0,2,0,1,0},
        '{0,0,2,0,2,0,1,0}, '{1,1,0,5,0,1,0,0}, '{0,0,0,5,0,1,0,1}
    };

    initial begin
        vec_t       tbl[$];
        logic       ok;
        logic [1:0] lidx, eidx;
        logic [3:0] prev;

        #2;
        rst  = 1'b1;
        rst2 = 1'b1;
        #1;
        chk("async reset time_left", 32'(time_left), 32'd5);
        chk("async reset mole", 32'(mole), 32'd0);
        chk("async reset score", 32'(score), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        rst2 = 1'b0;

        for (int i = 0; i < 10; i++) tbl.push_back(mkv(0, i % 2, (i % 3 == 0) ? 2 : 0, 5, 0, 0, 0, 0));
        for (int i = 0; i < NR; i++)
            tbl.push_back(mkv(rows[i][0], rows[i][1], rows[i][2], rows[i][3], rows[i][4], rows[i][5], rows[i][6], rows[i][7]));
        foreach (tbl[i]) apply(i, tbl[i]);

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lidx   = 2'd0;
        prev   = 4'b0000;
        for (int k = 0; k < 20; k++) begin
            wait_mole2(1'b0, ok);
            if (ok) wait_mole2(1'b1, ok);
            if (ok) begin
                eidx = ml_prev[1:0];
                if (eidx == lidx) eidx = eidx + 2'd1;
                chk($sformatf("spawn %0d hole", k), 32'(mole2), 32'(4'b0001 << eidx));
                if (k > 0) chk($sformatf("spawn %0d repeat", k), 32'(mole2 == prev), 32'd0);
                lidx = eidx;
                prev = mole2;
            end
        end

        for (int k = 1; k <= 256; k++) begin
            wait_mole2(1'b1, ok);
            hit2 = mole2;
            @(negedge clk);
            hit2 = '0;
            if (k >= 250) chk($sformatf("saturate hit %0d", k), 32'(score2), (k > 255) ? 32'd255 : 32'(k));
        end

        wait_mole2(1'b1, ok);
        #2;
        rst2 = 1'b1;
        #1;
        chk("midgame reset mole", 32'(mole2), 32'd0);
        chk("midgame reset score", 32'(score2), 32'd0);
        chk("midgame reset time_left", 32'(time2), 32'd127);
        chk("midgame reset flags", 32'({play2, over2}), 32'd0);
        @(negedge clk);
        rst2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
